// File: rtl/ram_sync_clr_if.sv
// rtl/ram_sync_clr_if.sv - access and status bundle for the clearable scratch RAM
interface ram_sync_clr_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) ();
  logic              we;
  logic              oe;
  logic              clr;
  logic [DATA_W-1:0] mem_in;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_out;
  logic              mem_valid;
  logic              busy;

  modport master (
    output we, oe, clr, mem_in, mem_add,
    input  mem_out, mem_valid, busy
  );

  modport slave (
    input  we, oe, clr, mem_in, mem_add,
    output mem_out, mem_valid, busy
  );
endinterface

// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - single-port RAM with registered read port and word-per-cycle clear engine
module ram_sync_clr #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 16,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input logic          clk,
  input logic          rst,
  ram_sync_clr_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam state_t            RST_STATE = CLEAR_ON_RST ? CLEAR : IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   mem_out_q, mem_out_d;
  logic                mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0]   ram_q [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                in_range;
  logic [DATA_W-1:0]   rd_data;

  // Addresses past the last word are not backed by storage and read as zero.
  assign in_range = ({1'b0, bus.mem_add} < DEPTH_W);
  assign rd_data  = in_range ? ram_q[bus.mem_add] : '0;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    mem_out_d   = mem_out_q;
    mem_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = bus.mem_add;
    wr_data     = bus.mem_in;

    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_q;
        wr_data = '0;
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        if (bus.clr) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          wr_en = bus.we && in_range;
          if (bus.oe) begin
            mem_valid_d = 1'b1;
            // A same-cycle write is forwarded so the read sees the new data.
            mem_out_d   = (bus.we && in_range) ? bus.mem_in : rd_data;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      clr_ptr_q   <= '0;
      mem_out_q   <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      mem_out_q   <= mem_out_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

  assign bus.mem_out   = mem_out_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.busy      = (state_q == CLEAR);

endmodule
